ram_arbiter2: RTL and testbench
===============================

Name: ram_arbiter2

Overview:
Two-requester round-robin arbiter that shares one single-port RAM16K-style memory. The memory has a combinational read and a write on the clock edge. Typical pairing: the CPU data port on port 0 and a DMA or screen-scan engine on port 1. The arbiter registers the grant, drives the memory bus from the granted port for one cycle, and returns registered read data to that port.

Parameters:
ADDR_W, 14, memory address width (RAM16K)
DATA_W, 16, data word width

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req0  in  1  port 0 request; held with we0/addr0/wdata0 stable until ack0 is seen
we0  in  1  port 0 write enable (1 = write, 0 = read)
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
ack0  out  1  port 0 grant; high during the cycle port 0 owns the memory
rdata0  out  DATA_W  port 0 read data
rvalid0  out  1  one-cycle pulse; rdata0 is valid
req1, we1, addr1, wdata1, ack1, rdata1, rvalid1  same as port 0, for port 1
mem_addr  out  ADDR_W  memory address
mem_load  out  1  memory write enable
mem_in  out  DATA_W  memory write data
mem_out  in  DATA_W  memory read data (combinational from mem_addr)

Behaviour:
- Reset (reset_n=0, asynchronous):
  - owner=NONE and prio=port 0.
  - ack0/1=0 and rvalid0/1=0.
  - rdata0/1=0.
  - mem_addr=0, mem_load=0, mem_in=0, effective immediately without a clock edge.
- State:
  - owner register: NONE, P0 or P1.
  - prio register: the port that wins a tie.
- Arbitration at each rising edge:
  - Eligible requests are eligible = {req1,req0} with the current owner's bit masked off.
  - If none is eligible: owner becomes NONE.
  - If exactly one is eligible: owner becomes that port.
  - If both are eligible: owner becomes the port named by prio.
  - When a port is granted, prio moves to the other port.
- Ack cycle (owner=Pk):
  - ackk=1.
  - mem_addr=addrk and mem_in=wdatak.
  - mem_load=wek.
  - All memory outputs are decoded combinationally from the owner register.
- Owner=NONE: mem_load=0, mem_addr=0, mem_in=0, and both acks are 0.
- Latency:
  - A request first sampled at edge E is acked during the cycle after E at the earliest.
  - A write commits at the edge that ends the ack cycle.
  - For a read, rdatak is captured from mem_out at the edge that ends the ack cycle. rvalidk pulses for the next cycle.
  - A read therefore completes 2 cycles after the request is sampled.
  - rdatak holds its value until the next read on that port completes.
  - Writes never pulse rvalid.
- Handshake:
  - The requester must hold its request and payload until it observes ack.
  - If req is still high in the cycle after ack, that is a new request.
  - Because of the owner mask, one port alone gets at most one access every 2 cycles.
  - Two contending ports alternate every cycle: ack0, ack1, ack0, … This gives full memory throughput.
- Simultaneous events:
  - Both ports writing the same address in consecutive cycles: the later ack wins; ordering is set by prio.
  - A read in the cycle after a write to the same address returns the new data.
- Reset mid-operation: if reset_n falls during a write ack cycle, mem_load drops asynchronously and the write does not commit. Any pending rvalid is cleared.
- Boundaries:
  - Addresses 0 to 2^ADDR_W−1, with no wrap or translation.
  - Request inputs are ignored while reset_n=0.

Decomposition:
- Shared package: the ADDR_W and DATA_W defaults, plus the owner encoding constants OWN_NONE=2'b00, OWN_P0=2'b01, OWN_P1=2'b10.
- Sub-module rr_pick2 holds the owner and prio registers and the mask-and-pick logic.
- The top level holds the bus muxing, the rdata/rvalid registers, and the outputs.

Test Plan:
1. Assert reset_n=0 mid-simulation with random requests → all outputs 0 immediately. After release with no requests → owner stays NONE and mem_load=0.
2. Port 0 write: addr0=0x0005, wdata0=0xBEEF, we0=1, sampled at edge E → in the next cycle ack0=1, mem_addr=0x0005, mem_in=0xBEEF, mem_load=1. Then port 1 read of 0x0005 → ack1 one cycle after sampling; rdata1=0xBEEF with rvalid1=1 two cycles after sampling.
3. Both ports raise reads at the same edge right after reset (addr0=0x0010, addr1=0x0020) → ack0, then ack1 in consecutive cycles. rvalid0 then rvalid1 carry the respective memory contents.
4. req0 held high continuously, req1=0 → ack0 pattern 1,0,1,0; mem_load is never high in a NONE cycle.
5. Both ports continuously request writes to 0x3FFF with data 0x1111 (port 0) and 0x2222 (port 1) → grants alternate. The final memory value matches the last-acked port. The highest address is accepted.
6. Port 1 write of 0xAAAA to 0x0100; reset_n pulsed low during its ack cycle → mem_load falls without a clock edge. A later read of 0x0100 returns the pre-existing value, not 0xAAAA.

Source files
------------

// File: rtl/ram_arbiter2_pkg.sv
// +----------------------------------------------------------------------------+
// | ram_arbiter2_pkg : shared widths and owner encoding for ram_arbiter2       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package ram_arbiter2_pkg;
  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 16;

  // One-hot owner bits double as the port mask for the next arbitration.
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_P0   = 2'b01,
    OWN_P1   = 2'b10
  } owner_t;
endpackage

`default_nettype wire

// File: rtl/ram_arbiter2_if.sv
// +----------------------------------------------------------------------------+
// | ram_arbiter2_if : two requester ports plus the shared memory bus           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface ram_arbiter2_if
  import ram_arbiter2_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;
  logic              rvalid0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;
  logic              rvalid1;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_load;
  logic [DATA_W-1:0] mem_in;
  logic [DATA_W-1:0] mem_out;

  // Requesters and the memory model.
  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  ack0, rdata0, rvalid0,
    input  ack1, rdata1, rvalid1,
    input  mem_addr, mem_load, mem_in,
    output mem_out
  );

  // The arbiter.
  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output ack0, rdata0, rvalid0,
    output ack1, rdata1, rvalid1,
    output mem_addr, mem_load, mem_in,
    input  mem_out
  );
endinterface

`default_nettype wire

// File: rtl/ram_arbiter2_rr_pick2.sv
// +----------------------------------------------------------------------------+
// | ram_arbiter2_rr_pick2 : owner/prio registers with mask-and-pick logic      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module ram_arbiter2_rr_pick2
  import ram_arbiter2_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       reset_n,
  input  wire logic [1:0] i_req,
  output owner_t          o_owner
);
  owner_t     r_owner;
  logic       r_prio;    // 0: port 0 wins a tie, 1: port 1 wins
  logic [1:0] w_mask;
  logic [1:0] w_elig;
  owner_t     w_next;

  always_comb begin
    w_mask = r_owner;
    w_elig = i_req & ~w_mask;
    w_next = OWN_NONE;
    case (w_elig)
      2'b01:   w_next = OWN_P0;
      2'b10:   w_next = OWN_P1;
      2'b11:   w_next = r_prio ? OWN_P1 : OWN_P0;
      default: w_next = OWN_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner <= OWN_NONE;
      r_prio  <= 1'b0;
    end else begin
      r_owner <= w_next;
      if (w_next == OWN_P0)
        r_prio <= 1'b1;
      else if (w_next == OWN_P1)
        r_prio <= 1'b0;
    end
  end

  assign o_owner = r_owner;
endmodule

`default_nettype wire

// File: rtl/ram_arbiter2.sv
// +----------------------------------------------------------------------------+
// | ram_arbiter2 : round-robin sharing of one single-port RAM by two ports     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module ram_arbiter2
  import ram_arbiter2_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
)(
  input wire logic      clk,
  input wire logic      reset_n,
  ram_arbiter2_if.slave bus
);
  owner_t            w_owner;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_din;
  logic              w_load;
  logic              w_rd0;
  logic              w_rd1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              r_rvalid0;
  logic              r_rvalid1;

  ram_arbiter2_rr_pick2 u_rr_pick2 (
    .clk     (clk),
    .reset_n (reset_n),
    .i_req   ({bus.req1, bus.req0}),
    .o_owner (w_owner)
  );

  // Bus is a pure decode of the owner register, so reset clears it at once.
  always_comb begin
    w_addr = '0;
    w_din  = '0;
    w_load = 1'b0;
    case (w_owner)
      OWN_P0: begin
        w_addr = bus.addr0;
        w_din  = bus.wdata0;
        w_load = bus.we0;
      end
      OWN_P1: begin
        w_addr = bus.addr1;
        w_din  = bus.wdata1;
        w_load = bus.we1;
      end
      default: ;
    endcase
  end

  assign w_rd0 = (w_owner == OWN_P0) && !bus.we0;
  assign w_rd1 = (w_owner == OWN_P1) && !bus.we1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata0  <= '0;
      r_rdata1  <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_rd0;
      r_rvalid1 <= w_rd1;
      if (w_rd0)
        r_rdata0 <= bus.mem_out;
      if (w_rd1)
        r_rdata1 <= bus.mem_out;
    end
  end

  assign bus.ack0     = (w_owner == OWN_P0);
  assign bus.ack1     = (w_owner == OWN_P1);
  assign bus.mem_addr = w_addr;
  assign bus.mem_in   = w_din;
  assign bus.mem_load = w_load;
  assign bus.rdata0   = r_rdata0;
  assign bus.rdata1   = r_rdata1;
  assign bus.rvalid0  = r_rvalid0;
  assign bus.rvalid1  = r_rvalid1;
endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter2.sv
// +----------------------------------------------------------------------------+
// | tb_ram_arbiter2 : directed vectors plus randomized model comparison        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ram_arbiter2;
  import ram_arbiter2_pkg::*;

  localparam int AW    = 14;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter2_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  ram_arbiter2 #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  // Memory: combinational read, write on the clock edge.
  logic [DW-1:0] mem     [0:DEPTH-1];
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  logic          mem_init = 1'b0;

  function automatic logic [DW-1:0] pat(int a);
    return DW'(a * 3 + 32'h1000);
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= pat(i);
    end else if (bus.mem_load) begin
      mem[bus.mem_addr] <= bus.mem_in;
    end
  end
  assign bus.mem_out = mem[bus.mem_addr];

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic k0, logic k1, logic ld, logic [AW-1:0] ma,
                         logic [DW-1:0] mi, logic v0, logic v1,
                         logic [DW-1:0] q0, logic [DW-1:0] q1);
    chk({tag, ".ack0"},     32'(bus.ack0),     32'(k0));
    chk({tag, ".ack1"},     32'(bus.ack1),     32'(k1));
    chk({tag, ".mem_load"}, 32'(bus.mem_load), 32'(ld));
    chk({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'(ma));
    chk({tag, ".mem_in"},   32'(bus.mem_in),   32'(mi));
    chk({tag, ".rvalid0"},  32'(bus.rvalid0),  32'(v0));
    chk({tag, ".rvalid1"},  32'(bus.rvalid1),  32'(v1));
    chk({tag, ".rdata0"},   32'(bus.rdata0),   32'(q0));
    chk({tag, ".rdata1"},   32'(bus.rdata1),   32'(q1));
  endtask

  task automatic clear_inputs();
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic init_mems();
    mem_init = 1'b1;
    @(posedge clk); #1;
    mem_init = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);
  endtask

  // Directed vectors: inputs held across one edge, outputs checked after it.
  typedef struct {
    bit rst;
    bit r0; bit w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    bit r1; bit w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    bit k0; bit k1; bit ld; logic [AW-1:0] ma; logic [DW-1:0] mi;
    bit v0; bit v1; logic [DW-1:0] q0; logic [DW-1:0] q1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit r0, bit w0, int a0, int d0, bit r1, bit w1, int a1, int d1,
                              bit k0, bit k1, bit ld, int ma, int mi, bit v0, bit v1, int q0, int q1);
    vec_t v;
    v.rst = rst;
    v.r0 = r0; v.w0 = w0; v.a0 = AW'(a0); v.d0 = DW'(d0);
    v.r1 = r1; v.w1 = w1; v.a1 = AW'(a1); v.d1 = DW'(d1);
    v.k0 = k0; v.k1 = k1; v.ld = ld; v.ma = AW'(ma); v.mi = DW'(mi);
    v.v0 = v0; v.v1 = v1; v.q0 = DW'(q0); v.q1 = DW'(q1);
    return v;
  endfunction

  // Reference model state: owner 0=none, 1=port0, 2=port1; prio is the tie-winning port.
  int            m_owner;
  int            m_prio;
  logic [DW-1:0] e_rd [2];
  bit            e_rv [2];
  bit            q_req [2];
  bit            q_we  [2];
  logic [AW-1:0] q_addr [2];
  logic [DW-1:0] q_wd   [2];

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AW'(16383 - $urandom_range(0, 3));
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic new_req(int k);
    q_req[k]  = ($urandom_range(0, 2) != 0);
    q_we[k]   = 1'($urandom_range(0, 1));
    q_addr[k] = rnd_addr();
    q_wd[k]   = DW'($urandom);
  endtask

  task automatic drive_q();
    bus.req0 = q_req[0]; bus.we0 = q_we[0]; bus.addr0 = q_addr[0]; bus.wdata0 = q_wd[0];
    bus.req1 = q_req[1]; bus.we1 = q_we[1]; bus.addr1 = q_addr[1]; bus.wdata1 = q_wd[1];
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_prio  = 0;
    for (int p = 0; p < 2; p++) begin
      e_rd[p] = '0; e_rv[p] = 0;
      q_req[p] = 0; q_we[p] = 0; q_addr[p] = '0; q_wd[p] = '0;
    end
  endtask

  task automatic run_random(int n, string tag);
    for (int c = 0; c < n; c++) begin
      int  prev;
      int  nxt;
      bit  el0;
      bit  el1;
      logic          x_ld;
      logic [AW-1:0] x_ma;
      logic [DW-1:0] x_mi;
      @(posedge clk); #1;
      // The access granted for the cycle just ended completes now.
      e_rv[0] = 0;
      e_rv[1] = 0;
      if (m_owner != 0) begin
        if (q_we[m_owner-1]) ref_mem[q_addr[m_owner-1]] = q_wd[m_owner-1];
        else begin
          e_rd[m_owner-1] = ref_mem[q_addr[m_owner-1]];
          e_rv[m_owner-1] = 1;
        end
      end
      el0 = q_req[0] && (m_owner != 1);
      el1 = q_req[1] && (m_owner != 2);
      if (el0 && el1)  nxt = m_prio + 1;
      else if (el0)    nxt = 1;
      else if (el1)    nxt = 2;
      else             nxt = 0;
      if (nxt != 0) m_prio = 2 - nxt;
      prev    = m_owner;
      m_owner = nxt;

      x_ld = 0; x_ma = '0; x_mi = '0;
      if (m_owner != 0) begin
        x_ld = q_we[m_owner-1];
        x_ma = q_addr[m_owner-1];
        x_mi = q_wd[m_owner-1];
      end
      chk_all($sformatf("%s%0d", tag, c), m_owner == 1, m_owner == 2, x_ld, x_ma, x_mi,
              e_rv[0], e_rv[1], e_rd[0], e_rd[1]);

      if (prev != 0) new_req(prev - 1);
      for (int p = 0; p < 2; p++)
        if (!q_req[p] && m_owner != p + 1 && $urandom_range(0, 1) == 1) new_req(p);
      drive_q();
    end
  endtask

  initial begin
    clear_inputs();
    init_mems();
    chk_all("reset", 0, 0, 0, '0, '0, 0, 0, '0, '0);

    // Port 0 write, then port 1 reads it back.
    tbl.push_back(mk(1, 1,1,'h5,'hBEEF,   0,0,0,0,        1,0,1,'h5,'hBEEF,   0,0,0,0));
    tbl.push_back(mk(0, 0,1,'h5,'hBEEF,   1,0,'h5,0,      0,1,0,'h5,0,        0,0,0,0));
    tbl.push_back(mk(0, 0,1,'h5,'hBEEF,   0,0,'h5,0,      0,0,0,0,0,          0,1,0,'hBEEF));
    tbl.push_back(mk(0, 0,0,0,0,          0,0,0,0,        0,0,0,0,0,          0,0,0,'hBEEF));
    // Simultaneous reads right after reset.
    tbl.push_back(mk(1, 1,0,'h10,0,       1,0,'h20,0,     1,0,0,'h10,0,       0,0,0,0));
    tbl.push_back(mk(0, 0,0,'h10,0,       1,0,'h20,0,     0,1,0,'h20,0,       1,0,'h1030,0));
    tbl.push_back(mk(0, 0,0,'h10,0,       0,0,'h20,0,     0,0,0,0,0,          0,1,'h1030,'h1060));
    tbl.push_back(mk(0, 0,0,0,0,          0,0,0,0,        0,0,0,0,0,          0,0,'h1030,'h1060));
    // Port 0 alone, request held: grants every other cycle.
    tbl.push_back(mk(1, 1,1,'h30,'h1234,  0,0,0,0,        1,0,1,'h30,'h1234,  0,0,0,0));
    tbl.push_back(mk(0, 1,1,'h30,'h1234,  0,0,0,0,        0,0,0,0,0,          0,0,0,0));
    tbl.push_back(mk(0, 1,1,'h30,'h1234,  0,0,0,0,        1,0,1,'h30,'h1234,  0,0,0,0));
    tbl.push_back(mk(0, 1,1,'h30,'h1234,  0,0,0,0,        0,0,0,0,0,          0,0,0,0));
    // Contending writes to the top address; prio currently favours port 1.
    tbl.push_back(mk(0, 1,1,'h3FFF,'h1111, 1,1,'h3FFF,'h2222, 0,1,1,'h3FFF,'h2222, 0,0,0,0));
    tbl.push_back(mk(0, 1,1,'h3FFF,'h1111, 1,1,'h3FFF,'h2222, 1,0,1,'h3FFF,'h1111, 0,0,0,0));
    tbl.push_back(mk(0, 1,1,'h3FFF,'h1111, 1,1,'h3FFF,'h2222, 0,1,1,'h3FFF,'h2222, 0,0,0,0));
    tbl.push_back(mk(0, 0,1,'h3FFF,'h1111, 0,1,'h3FFF,'h2222, 0,0,0,0,0,           0,0,0,0));
    tbl.push_back(mk(0, 1,0,'h3FFF,0,      0,0,0,0,           1,0,0,'h3FFF,0,      0,0,0,0));
    tbl.push_back(mk(0, 0,0,'h3FFF,0,      0,0,0,0,           0,0,0,0,0,           1,0,'h2222,0));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) apply_reset();
      bus.req0 = tbl[i].r0; bus.we0 = tbl[i].w0; bus.addr0 = tbl[i].a0; bus.wdata0 = tbl[i].d0;
      bus.req1 = tbl[i].r1; bus.we1 = tbl[i].w1; bus.addr1 = tbl[i].a1; bus.wdata1 = tbl[i].d1;
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), tbl[i].k0, tbl[i].k1, tbl[i].ld, tbl[i].ma, tbl[i].mi,
              tbl[i].v0, tbl[i].v1, tbl[i].q0, tbl[i].q1);
    end

    // Reset during a port 1 write ack cycle aborts the write.
    apply_reset();
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 14'h0100; bus.wdata1 = 16'hAAAA;
    @(posedge clk); #1;
    chk("abort.ack1_before", 32'(bus.ack1), 32'd1);
    chk("abort.load_before", 32'(bus.mem_load), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort.load_async", 32'(bus.mem_load), 32'd0);
    chk("abort.ack1_async", 32'(bus.ack1), 32'd0);
    chk("abort.addr_async", 32'(bus.mem_addr), 32'd0);
    @(posedge clk); #1;
    clear_inputs();
    reset_n = 1'b1;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 14'h0100;
    @(posedge clk); #1;
    chk("abort.ack0_read", 32'(bus.ack0), 32'd1);
    bus.req0 = 0;
    @(posedge clk); #1;
    chk("abort.rvalid0", 32'(bus.rvalid0), 32'd1);
    chk("abort.rdata0", 32'(bus.rdata0), 32'(pat('h100)));

    // Randomized traffic against the reference model, with a reset in the middle.
    apply_reset();
    init_mems();
    model_reset();
    drive_q();
    run_random(300, "rnda");

    #2 reset_n = 1'b0;
    #1;
    chk_all("midrst", 0, 0, 0, '0, '0, 0, 0, '0, '0);
    model_reset();
    drive_q();
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("idle%0d.ack0", i), 32'(bus.ack0), 32'd0);
      chk($sformatf("idle%0d.ack1", i), 32'(bus.ack1), 32'd0);
      chk($sformatf("idle%0d.load", i), 32'(bus.mem_load), 32'd0);
    end
    run_random(300, "rndb");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
